u712_ta_sequencer: RTL and testbench

//  Sequences every MC68040 bus cycle decoded to U712 register or RAM space. It launches the owning

---
 rtl/u712_ta_sequencer_pkg.sv | 25 ++
 rtl/u712_ta_sequencer_timeout.sv | 48 ++++
 rtl/u712_ta_sequencer.sv | 168 ++++++++++++++++
 tb/tb_u712_ta_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/u712_ta_sequencer_pkg.sv
//==============================================================================
// Module : u712_ta_sequencer_pkg
// Brief  : Shared state encodings, size codes and defaults for the U712 sequencer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package u712_ta_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACK     = 3'd2,
        ST_RECOVER = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam int DEF_BURST_BEATS    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

`default_nettype wire

// File: rtl/u712_ta_sequencer_timeout.sv
//==============================================================================
// Module : u712_bus_timeout
// Brief  : Loadable up-counter with clear/enable and a terminal-count flag.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module u712_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic                 i_load,
    input  logic [TIMEOUT_W-1:0] i_load_val,
    output logic                 o_tc
);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (i_enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flag is raised on the last allowed clock so the caller can act on the same edge.
    assign o_tc = (count_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/u712_ta_sequencer.sv
//==============================================================================
// Module : u712_ta_sequencer
// Brief  : Launches U712 register/RAM responders, counts beats, drives TA/TBI/TEA.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module u712_ta_sequencer
    import u712_ta_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TIMEOUT_W      = 8,
    parameter int BURST_BEATS    = DEF_BURST_BEATS
) (
    input  logic       CLK40,
    input  logic       RESET,
    input  logic       nTS,
    input  logic [1:0] SIZ,
    input  logic       REGSPACE,
    input  logic       RAMSPACE,
    input  logic       REG_RDY,
    input  logic       RAM_RDY,
    input  logic       DMA_ABORT,
    output logic       REG_GO,
    output logic       RAM_GO,
    output logic       BURST,
    output logic       TA_O,
    output logic       TBI_O,
    output logic       TEA_O,
    output logic       DRV_EN,
    output logic       BUSY
);

    state_t     state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic       space_reg_q, space_reg_d;
    logic       burst_q, burst_d;
    logic       reg_go_q, reg_go_d;
    logic       ram_go_q, ram_go_d;
    logic       ta_q, ta_d;
    logic       tbi_q, tbi_d;
    logic       tea_q, tea_d;
    logic       drv_q, drv_d;
    logic       busy_q, busy_d;

    logic w_hit;
    logic w_rdy;
    logic w_tc;
    logic w_in_wait;

    assign w_hit     = !nTS && (REGSPACE || RAMSPACE);
    assign w_rdy     = space_reg_q ? REG_RDY : RAM_RDY;
    assign w_in_wait = (state_q == ST_WAIT);

    u712_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk        (CLK40),
        .rst        (RESET),
        .i_clear    (!w_in_wait),
        .i_enable   (w_in_wait),
        .i_load     (1'b0),
        .i_load_val ({TIMEOUT_W{1'b0}}),
        .o_tc       (w_tc)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        space_reg_d = space_reg_q;
        burst_d     = burst_q;
        reg_go_d    = 1'b0;
        ram_go_d    = 1'b0;
        ta_d        = 1'b0;
        tbi_d       = 1'b0;
        tea_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                burst_d = 1'b0;
                if (w_hit) begin
                    state_d     = ST_WAIT;
                    space_reg_d = REGSPACE;
                    burst_d     = !REGSPACE && (SIZ == SIZ_LINE) && !DMA_ABORT;
                    beat_d      = 2'd0;
                    reg_go_d    = REGSPACE;
                    ram_go_d    = !REGSPACE;
                end
            end
            ST_WAIT: begin
                // An abort seen up to and including the first ready demotes the burst.
                if (beat_q == 2'd0) begin
                    burst_d = burst_q && !DMA_ABORT;
                end
                if (w_rdy) begin
                    state_d = ST_ACK;
                    ta_d    = 1'b1;
                    tbi_d   = (beat_q == 2'd0) && !burst_d;
                end else if (w_tc) begin
                    state_d = ST_ERR;
                    tea_d   = 1'b1;
                end
            end
            ST_ACK: begin
                beat_d = beat_q + 2'd1;
                if (burst_q && (beat_q != 2'(BURST_BEATS - 1))) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            ST_ERR: begin
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
                burst_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drv_d  = (state_d == ST_ACK) || (state_d == ST_ERR) || (state_d == ST_RECOVER);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            beat_q      <= 2'd0;
            space_reg_q <= 1'b0;
            burst_q     <= 1'b0;
            reg_go_q    <= 1'b0;
            ram_go_q    <= 1'b0;
            ta_q        <= 1'b0;
            tbi_q       <= 1'b0;
            tea_q       <= 1'b0;
            drv_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            space_reg_q <= space_reg_d;
            burst_q     <= burst_d;
            reg_go_q    <= reg_go_d;
            ram_go_q    <= ram_go_d;
            ta_q        <= ta_d;
            tbi_q       <= tbi_d;
            tea_q       <= tea_d;
            drv_q       <= drv_d;
            busy_q      <= busy_d;
        end
    end

    assign REG_GO = reg_go_q;
    assign RAM_GO = ram_go_q;
    assign BURST  = burst_q;
    assign TA_O   = ta_q;
    assign TBI_O  = tbi_q;
    assign TEA_O  = tea_q;
    assign DRV_EN = drv_q;
    assign BUSY   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_u712_ta_sequencer.sv
//==============================================================================
// Module : tb_u712_ta_sequencer
// Brief  : Directed self-checking bench for the U712 TA sequencer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_u712_ta_sequencer;

    logic       CLK40 = 1'b0;
    logic       RESET;
    logic       nTS;
    logic [1:0] SIZ;
    logic       REGSPACE, RAMSPACE, REG_RDY, RAM_RDY, DMA_ABORT;
    logic       REG_GO, RAM_GO, BURST, TA_O, TBI_O, TEA_O, DRV_EN, BUSY;
    logic [7:0] w_outs;

    int n_tests = 0;
    int n_fail  = 0;

    // Output vector bit order: REG_GO RAM_GO BURST TA TBI TEA DRV_EN BUSY
    localparam logic [7:0] O_IDLE    = 8'b0000_0000;
    localparam logic [7:0] O_BUSY    = 8'b0000_0001;
    localparam logic [7:0] O_RGO     = 8'b1000_0001;
    localparam logic [7:0] O_MGO     = 8'b0100_0001;
    localparam logic [7:0] O_MGO_B   = 8'b0110_0001;
    localparam logic [7:0] O_WAIT_B  = 8'b0010_0001;
    localparam logic [7:0] O_ACK_TBI = 8'b0001_1011;
    localparam logic [7:0] O_ACK_B   = 8'b0011_0011;
    localparam logic [7:0] O_REC     = 8'b0000_0011;
    localparam logic [7:0] O_REC_B   = 8'b0010_0011;
    localparam logic [7:0] O_ERR     = 8'b0000_0111;

    always #5 CLK40 = ~CLK40;

    assign w_outs = {REG_GO, RAM_GO, BURST, TA_O, TBI_O, TEA_O, DRV_EN, BUSY};

    u712_ta_sequencer dut (
        .CLK40     (CLK40),
        .RESET     (RESET),
        .nTS       (nTS),
        .SIZ       (SIZ),
        .REGSPACE  (REGSPACE),
        .RAMSPACE  (RAMSPACE),
        .REG_RDY   (REG_RDY),
        .RAM_RDY   (RAM_RDY),
        .DMA_ABORT (DMA_ABORT),
        .REG_GO    (REG_GO),
        .RAM_GO    (RAM_GO),
        .BURST     (BURST),
        .TA_O      (TA_O),
        .TBI_O     (TBI_O),
        .TEA_O     (TEA_O),
        .DRV_EN    (DRV_EN),
        .BUSY      (BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp);
        @(posedge CLK40);
        #1;
        chk(tag, {24'd0, w_outs}, {24'd0, exp});
    endtask

    task automatic start(input string tag, input logic rs, input logic ms,
                         input logic [1:0] sz, input logic [7:0] exp);
        nTS      = 1'b0;
        REGSPACE = rs;
        RAMSPACE = ms;
        SIZ      = sz;
        cyc(tag, exp);
        nTS      = 1'b1;
        REGSPACE = 1'b0;
        RAMSPACE = 1'b0;
        SIZ      = 2'b00;
    endtask

    // Counts clocks whose outputs differ from a steady expected value.
    task automatic hold(input string tag, input int n, input logic [7:0] exp);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK40);
            #1;
            if (w_outs !== exp) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        RESET = 1'b1; nTS = 1'b1; SIZ = 2'b00;
        REGSPACE = 1'b0; RAMSPACE = 1'b0; REG_RDY = 1'b0; RAM_RDY = 1'b0; DMA_ABORT = 1'b0;
        repeat (2) @(posedge CLK40);
        #1;
        chk("reset_outs", {24'd0, w_outs}, {24'd0, O_IDLE});
        RESET = 1'b0;
        cyc("reset_idle", O_IDLE);

        // Register cycle, ready two clocks after REG_GO
        start("t1_go", 1'b1, 1'b0, 2'b01, O_RGO);
        cyc("t1_wait1", O_BUSY);
        REG_RDY = 1'b1;
        cyc("t1_ack", O_ACK_TBI);
        REG_RDY = 1'b0;
        cyc("t1_recover", O_REC);
        cyc("t1_idle", O_IDLE);

        // RAM line, four clean beats
        start("t2_go", 1'b0, 1'b1, 2'b11, O_MGO_B);
        for (int b = 0; b < 4; b++) begin
            RAM_RDY = 1'b1;
            cyc($sformatf("t2_ack%0d", b), O_ACK_B);
            RAM_RDY = 1'b0;
            cyc($sformatf("t2_after%0d", b), (b < 3) ? O_WAIT_B : O_REC_B);
        end
        cyc("t2_idle", O_IDLE);

        // RAM line aborted before the first beat
        start("t3a_go", 1'b0, 1'b1, 2'b11, O_MGO_B);
        DMA_ABORT = 1'b1;
        cyc("t3a_demote", O_BUSY);
        DMA_ABORT = 1'b0;
        RAM_RDY   = 1'b1;
        cyc("t3a_ack", O_ACK_TBI);
        RAM_RDY = 1'b0;
        cyc("t3a_recover", O_REC);
        cyc("t3a_idle", O_IDLE);

        // RAM line with abort raised from beat 2 onward
        start("t3b_go", 1'b0, 1'b1, 2'b11, O_MGO_B);
        RAM_RDY = 1'b1;
        cyc("t3b_ack0", O_ACK_B);
        RAM_RDY   = 1'b0;
        DMA_ABORT = 1'b1;
        cyc("t3b_wait1", O_WAIT_B);
        cyc("t3b_wait1b", O_WAIT_B);
        for (int b = 1; b < 4; b++) begin
            RAM_RDY = 1'b1;
            cyc($sformatf("t3b_ack%0d", b), O_ACK_B);
            RAM_RDY = 1'b0;
            cyc($sformatf("t3b_after%0d", b), (b < 3) ? O_WAIT_B : O_REC_B);
        end
        DMA_ABORT = 1'b0;
        cyc("t3b_idle", O_IDLE);

        // Non-line RAM transfer inhibits burst
        start("t3c_go", 1'b0, 1'b1, 2'b10, O_MGO);
        RAM_RDY = 1'b1;
        cyc("t3c_ack", O_ACK_TBI);
        RAM_RDY = 1'b0;
        cyc("t3c_recover", O_REC);
        cyc("t3c_idle", O_IDLE);

        // Register timeout: TEA 255 clocks after REG_GO
        start("t4a_go", 1'b1, 1'b0, 2'b00, O_RGO);
        hold("t4a_wait", 254, O_BUSY);
        cyc("t4a_tea", O_ERR);
        cyc("t4a_recover", O_REC);
        cyc("t4a_idle", O_IDLE);

        // Ready on the terminal clock beats the timeout
        start("t4b_go", 1'b1, 1'b0, 2'b00, O_RGO);
        hold("t4b_wait", 254, O_BUSY);
        REG_RDY = 1'b1;
        cyc("t4b_ack", O_ACK_TBI);
        REG_RDY = 1'b0;
        cyc("t4b_recover", O_REC);
        cyc("t4b_idle", O_IDLE);

        // Transfer start with no decode hit
        start("t5_miss", 1'b0, 1'b0, 2'b11, O_IDLE);
        REGSPACE = 1'b1;
        cyc("t5_no_ts", O_IDLE);
        REGSPACE = 1'b0;

        // Both spaces hit: register wins, RAM ready ignored
        start("t6a_go", 1'b1, 1'b1, 2'b11, O_RGO);
        RAM_RDY = 1'b1;
        cyc("t6a_ignore_ram", O_BUSY);
        RAM_RDY = 1'b0;
        REG_RDY = 1'b1;
        cyc("t6a_ack", O_ACK_TBI);
        REG_RDY = 1'b0;
        cyc("t6a_recover", O_REC);
        cyc("t6a_idle", O_IDLE);

        // Reset during beat 2 of a burst
        start("t6b_go", 1'b0, 1'b1, 2'b11, O_MGO_B);
        RAM_RDY = 1'b1;
        cyc("t6b_ack0", O_ACK_B);
        RAM_RDY = 1'b0;
        cyc("t6b_wait1", O_WAIT_B);
        RAM_RDY = 1'b1;
        cyc("t6b_ack1", O_ACK_B);
        RAM_RDY = 1'b0;
        RESET   = 1'b1;
        #1;
        chk("t6b_async", {24'd0, w_outs}, {24'd0, O_IDLE});
        cyc("t6b_held", O_IDLE);
        RESET = 1'b0;
        cyc("t6b_idle", O_IDLE);
        start("t6b_relaunch", 1'b1, 1'b0, 2'b01, O_RGO);
        REG_RDY = 1'b1;
        cyc("t6b_ack", O_ACK_TBI);
        REG_RDY = 1'b0;
        cyc("t6b_recover", O_REC);
        cyc("t6b_end", O_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
